// File: rtl/fir2d_frame_sequencer.sv
// fir2d_frame_sequencer: frame control, line-buffer sequencing and tap/edge flags for a 3x3 separable FIR
module fir2d_frame_sequencer #(
   parameter int ADDR_WIDTH = 11,
   parameter int SIZE_WIDTH = 12,
   parameter int PIPE_LAT = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [SIZE_WIDTH-1:0] h_size_i,
   input  logic [SIZE_WIDTH-1:0] v_size_i,
   input  logic                  ce_i,
   output logic                  ready_o,
   output logic                  lb_wr_en_o,
   output logic [ADDR_WIDTH-1:0] lb_wr_addr_o,
   output logic                  lb_rd_en_o,
   output logic [ADDR_WIDTH-1:0] lb_rd_addr_o,
   output logic                  tap_valid_o,
   output logic                  top_rep_o,
   output logic                  bot_rep_o,
   output logic                  left_rep_o,
   output logic                  right_rep_o,
   output logic                  out_valid_o,
   output logic                  sof_o,
   output logic                  eol_o,
   output logic                  busy_o,
   output logic                  done_o
);
   typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DRAIN} state_t;
   state_t state, state_nx;
   logic [SIZE_WIDTH-1:0] h_size, v_size, h_cnt, v_cnt;
   logic [PIPE_LAT-1:0] ov_sr, sof_sr, eol_sr;
   logic accept, step, last_col, size_ok, start_ok;
   always_comb begin
      ready_o = state == FILL || state == RUN;
      accept = ce_i & ready_o;
      step = accept || state == FLUSH;
      last_col = h_cnt == h_size - SIZE_WIDTH'(1);
      size_ok = h_size_i != '0 && int'(h_size_i) <= 2**ADDR_WIDTH && v_size_i != '0;
      start_ok = state == IDLE && start_i && size_ok;
      lb_wr_en_o = accept;
      lb_rd_en_o = (accept && state == RUN) || state == FLUSH;
      lb_wr_addr_o = h_cnt[ADDR_WIDTH-1:0];
      lb_rd_addr_o = h_cnt[ADDR_WIDTH-1:0];
      done_o = state == DRAIN && !tap_valid_o && ov_sr == '0;
      busy_o = state != IDLE && !done_o;
      state_nx = state;
      case (state)
         IDLE:  state_nx = start_ok ? FILL : IDLE;
         FILL:  state_nx = (accept && last_col) ? (v_size > SIZE_WIDTH'(1) ? RUN : FLUSH) : FILL;
         RUN:   state_nx = (accept && last_col && v_cnt == v_size - SIZE_WIDTH'(1)) ? FLUSH : RUN;
         FLUSH: state_nx = last_col ? DRAIN : FLUSH;
         DRAIN: state_nx = done_o ? IDLE : DRAIN;
         default: state_nx = IDLE;
      endcase
   end
   // taps for output row v_cnt-1; v_cnt already points past the row being read
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         h_size <= '0;
         v_size <= '0;
         h_cnt <= '0;
         v_cnt <= '0;
         tap_valid_o <= 1'b0;
         top_rep_o <= 1'b0;
         bot_rep_o <= 1'b0;
         left_rep_o <= 1'b0;
         right_rep_o <= 1'b0;
         ov_sr <= '0;
         sof_sr <= '0;
         eol_sr <= '0;
      end else begin
         state <= state_nx;
         if (start_ok) begin
            h_size <= h_size_i;
            v_size <= v_size_i;
            h_cnt <= '0;
            v_cnt <= '0;
         end else if (step) begin
            h_cnt <= last_col ? '0 : h_cnt + SIZE_WIDTH'(1);
            v_cnt <= v_cnt + SIZE_WIDTH'(last_col);
         end
         tap_valid_o <= lb_rd_en_o;
         top_rep_o <= lb_rd_en_o && v_cnt == SIZE_WIDTH'(1);
         bot_rep_o <= lb_rd_en_o && v_cnt == v_size;
         left_rep_o <= lb_rd_en_o && h_cnt == '0;
         right_rep_o <= lb_rd_en_o && last_col;
         ov_sr <= (ov_sr << 1) | PIPE_LAT'(tap_valid_o);
         sof_sr <= (sof_sr << 1) | PIPE_LAT'(tap_valid_o & top_rep_o & left_rep_o);
         eol_sr <= (eol_sr << 1) | PIPE_LAT'(right_rep_o);
      end
   end
   assign out_valid_o = ov_sr[PIPE_LAT-1];
   assign sof_o = sof_sr[PIPE_LAT-1];
   assign eol_o = eol_sr[PIPE_LAT-1];
endmodule

// File: tb/tb_fir2d_frame_sequencer.sv
// tb_fir2d_frame_sequencer: frame table plus random frames checked against an event-order reference model
module tb_fir2d_frame_sequencer;
   localparam int AW = 11, SW = 12, PL = 6;
   typedef struct {int h; int v; int gap; bit bstart; int n_out;} vec_t;
   logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, ce_i = 1'b0;
   logic [SW-1:0] h_size_i = '0, v_size_i = '0;
   logic ready_o, lb_wr_en_o, lb_rd_en_o, tap_valid_o, top_rep_o, bot_rep_o, left_rep_o, right_rep_o;
   logic out_valid_o, sof_o, eol_o, busy_o, done_o;
   logic [AW-1:0] lb_wr_addr_o, lb_rd_addr_o;
   logic [34:0] outs;
   int vectors = 0, miscompares = 0, cyc = 0;
   bit mon = 0;
   int cur_h = 1, cur_v = 1, n_wr = 0, n_rd = 0, n_tap = 0, n_ov = 0, n_done = 0;
   int rdq[$], tapq[$];
   vec_t tbl[7];
   fir2d_frame_sequencer #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .PIPE_LAT(PL)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .h_size_i(h_size_i), .v_size_i(v_size_i), .ce_i(ce_i),
      .ready_o(ready_o), .lb_wr_en_o(lb_wr_en_o), .lb_wr_addr_o(lb_wr_addr_o), .lb_rd_en_o(lb_rd_en_o),
      .lb_rd_addr_o(lb_rd_addr_o), .tap_valid_o(tap_valid_o), .top_rep_o(top_rep_o), .bot_rep_o(bot_rep_o),
      .left_rep_o(left_rep_o), .right_rep_o(right_rep_o), .out_valid_o(out_valid_o), .sof_o(sof_o),
      .eol_o(eol_o), .busy_o(busy_o), .done_o(done_o)
   );
   assign outs = {ready_o, lb_wr_en_o, lb_wr_addr_o, lb_rd_en_o, lb_rd_addr_o, tap_valid_o, top_rep_o,
                  bot_rep_o, left_rep_o, right_rep_o, out_valid_o, sof_o, eol_o, busy_o, done_o};
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(string name, longint act, longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // reference model: taps/outputs arrive in raster order; row = k/H, col = k%H
   always @(negedge clk) if (mon) begin
      if (ce_i && !ready_o) chk("wr_while_not_ready", lb_wr_en_o, 0);
      if (lb_wr_en_o) begin
         chk("wr_addr", lb_wr_addr_o, n_wr % cur_h);
         chk("rd_with_wr", lb_rd_en_o, n_wr >= cur_h);
         n_wr++;
      end
      if (lb_rd_en_o) begin
         if (!lb_wr_en_o) chk("flush_after_input", n_wr, cur_h * cur_v);
         chk("rd_addr", lb_rd_addr_o, n_rd % cur_h);
         rdq.push_back(cyc);
         n_rd++;
      end
      if (tap_valid_o) begin
         if (rdq.size() == 0) chk("tap_without_read", 0, 1);
         else chk("tap_latency", cyc - rdq.pop_front(), 1);
         chk("tap_flags", {top_rep_o, bot_rep_o, left_rep_o, right_rep_o},
             {(n_tap / cur_h) == 0, (n_tap / cur_h) == cur_v - 1, (n_tap % cur_h) == 0, (n_tap % cur_h) == cur_h - 1});
         tapq.push_back(cyc);
         n_tap++;
      end
      if (out_valid_o) begin
         if (tapq.size() == 0) chk("out_without_tap", 0, 1);
         else chk("out_latency", cyc - tapq.pop_front(), PL);
         chk("sof", sof_o, n_ov == 0);
         chk("eol", eol_o, (n_ov % cur_h) == cur_h - 1);
         n_ov++;
      end
      if (done_o) begin
         n_done++;
         chk("done_after_all_outputs", n_ov, cur_h * cur_v);
      end
   end
   task automatic clear_model(int h, int v);
      cur_h = h;
      cur_v = v;
      n_wr = 0; n_rd = 0; n_tap = 0; n_ov = 0; n_done = 0;
      rdq.delete();
      tapq.delete();
      mon = 1;
   endtask
   task automatic start_frame(int h, int v);
      clear_model(h, v);
      start_i = 1'b1;
      h_size_i = SW'(h);
      v_size_i = SW'(v);
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("busy_rise", busy_o, 1);
   endtask
   task automatic feed(int gap, bit bstart);
      int i, budget;
      budget = cur_h * cur_v * (gap + 1) * 3 + cur_h + PL + 50;
      for (i = 0; i < budget; i++) begin
         ce_i = (gap == 0) || ($urandom_range(0, gap) == 0);
         if (bstart && i == 3) begin
            start_i = 1'b1;
            h_size_i = 7;
            v_size_i = 7;
         end else start_i = 1'b0;
         @(posedge clk); #1;
         if (done_o) break;
      end
      ce_i = 1'b0;
      start_i = 1'b0;
      if (i == budget) chk("done_timeout", 0, 1);
   endtask
   task automatic check_counts(int n);
      chk("writes", n_wr, n);
      chk("reads", n_rd, n);
      chk("taps", n_tap, n);
      chk("outputs", n_ov, n);
      chk("done_count", n_done, 1);
   endtask
   task automatic end_frame(int n);
      @(posedge clk); #1;
      check_counts(n);
      chk("busy_fall", busy_o, 0);
   endtask
   initial begin
      tbl[0] = '{4, 3, 0, 1'b0, 12};
      tbl[1] = '{1, 1, 0, 1'b0, 1};
      tbl[2] = '{4, 3, 1, 1'b1, 12};
      tbl[3] = '{2048, 2, 3, 1'b0, 4096};
      tbl[4] = '{5, 1, 2, 1'b0, 5};
      tbl[5] = '{1, 4, 0, 1'b0, 4};
      tbl[6] = '{2, 3, 1, 1'b1, 6};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", outs, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_outputs", outs, 0);
      @(posedge clk); #1;
      for (int t = 0; t < 7; t++) begin
         start_frame(tbl[t].h, tbl[t].v);
         feed(tbl[t].gap, tbl[t].bstart);
         end_frame(tbl[t].n_out);
      end
      for (int t = 0; t < 5; t++) begin
         int h, v;
         h = $urandom_range(1, 16);
         v = $urandom_range(1, 5);
         start_frame(h, v);
         feed($urandom_range(0, 2), 1'b0);
         end_frame(h * v);
      end
      begin
         int bad[4][2] = '{'{0, 3}, '{2049, 2}, '{4, 0}, '{4095, 4095}};
         clear_model(1, 1);
         for (int t = 0; t < 4; t++) begin
            start_i = 1'b1;
            h_size_i = SW'(bad[t][0]);
            v_size_i = SW'(bad[t][1]);
            @(posedge clk); #1;
            start_i = 1'b0;
            chk("illegal_start_busy", busy_o, 0);
            @(posedge clk); #1;
            chk("illegal_start_ready", ready_o, 0);
         end
         chk("illegal_start_done", n_done, 0);
      end
      start_frame(8, 3);
      ce_i = 1'b1;
      repeat (13) @(posedge clk);
      #1;
      ce_i = 1'b0;
      chk("pre_reset_col", lb_wr_addr_o, 5);
      mon = 0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midframe_reset_outputs", outs, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      clear_model(8, 3);
      repeat (20) @(posedge clk);
      #1;
      chk("abandoned_done", n_done, 0);
      chk("abandoned_outputs", n_ov, 0);
      start_frame(3, 2);
      feed(0, 1'b0);
      end_frame(6);
      start_frame(2, 1);
      feed(0, 1'b0);
      start_i = 1'b1;
      h_size_i = 3;
      v_size_i = 2;
      @(posedge clk); #1;
      chk("start_on_done_dropped", busy_o, 0);
      check_counts(2);
      clear_model(3, 2);
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("start_after_done_busy", busy_o, 1);
      feed(1, 1'b0);
      end_frame(6);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
